ram3840_arbiter: RTL and testbench

Two-requester access arbiter for the single-port RAM3840 (3840 × 16-bit words, 12-bit address, synchronous write, one-cycle registered read). Requester 0 is the CPU data port and requester 1 is the display scan-out engine. Each cycle the arbiter grants at most one request and drives the RAM address, data and load lines. It returns read data on the granted port one cycle later and rejects addresses at or above 3840 with an error pulse.

---
 rtl/ram3840_pkg.sv | 24 ++
 rtl/ram3840_arb_pick.sv | 27 ++
 rtl/ram3840_arbiter.sv | 97 +++++++++
 tb/tb_ram3840_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ram3840_pkg.sv
// rtl/ram3840_pkg.sv - shared widths, port ids and return-tag type for the RAM3840 arbiter
package ram3840_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] DEPTH = 12'd3840;
  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_VID = 1'b1
  } port_e;

  typedef struct packed {
    port_e port;
    logic  rd;
    logic  err;
  } rd_tag_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < DEPTH;
  endfunction

endpackage

// File: rtl/ram3840_arb_pick.sv
// rtl/ram3840_arb_pick.sv - winner selection for the RAM3840 arbiter
// RAM3840_ARB_RR_EN selects round-robin ties; otherwise fixed priority with port-1 anti-starvation.
module ram3840_arb_pick import ram3840_pkg::*; (
  input  logic       req0_i,
  input  logic       req1_i,
  input  port_e      last_gnt_i,
  input  logic [2:0] starve_cnt_i,
  output logic       pick0_o,
  output logic       pick1_o,
  output logic       starve_en_o
);

`ifdef RAM3840_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = ^starve_cnt_i;
  assign starve_en_o   = 1'b0;
  assign pick1_o       = req1_i & (~req0_i | (last_gnt_i == PORT_CPU));
`else
  logic unused_last;
  assign unused_last = ^last_gnt_i;
  assign starve_en_o = 1'b1;
  assign pick1_o     = req1_i & (~req0_i | (starve_cnt_i == STARVE_LIMIT));
`endif

  assign pick0_o = req0_i & ~pick1_o;

endmodule

// File: rtl/ram3840_arbiter.sv
// rtl/ram3840_arbiter.sv - two-port access arbiter in front of the single-port RAM3840
// Tie policy chosen by RAM3840_ARB_RR_EN (round-robin) or its absence (fixed priority).
module ram3840_arbiter import ram3840_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  port_e             last_gnt_q, last_gnt_d;
  logic [2:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  rd_tag_t           pend_q, pend_d;
  logic              pick0, pick1, starve_en;
  logic              gnt_any, sel_we, in_range;
  logic [ADDR_W-1:0] sel_addr;

  ram3840_arb_pick u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_gnt_i   (last_gnt_q),
    .starve_cnt_i (starve_cnt_q),
    .pick0_o      (pick0),
    .pick1_o      (pick1),
    .starve_en_o  (starve_en)
  );

  assign gnt0     = pick0 & rst_n;
  assign gnt1     = pick1 & rst_n;
  assign gnt_any  = gnt0 | gnt1;
  assign sel_addr = gnt1 ? addr1 : addr0;
  assign sel_we   = gnt1 ? we1 : we0;
  assign in_range = addr_in_range(sel_addr);

  // Address bus parks on the last granted address so the RAM input stays quiet when idle.
  assign ram_address = gnt_any ? sel_addr : addr_q;
  assign ram_in      = gnt1 ? wdata1 : wdata0;
  assign ram_load    = gnt_any & sel_we & in_range;

  always_comb begin
    last_gnt_d   = last_gnt_q;
    starve_cnt_d = starve_cnt_q;
    pend_d       = '0;
    if (gnt_any) begin
      last_gnt_d  = gnt1 ? PORT_VID : PORT_CPU;
      pend_d.port = gnt1 ? PORT_VID : PORT_CPU;
      pend_d.rd   = ~sel_we;
      pend_d.err  = ~in_range;
    end
    if (!starve_en || !req1 || gnt1) begin
      starve_cnt_d = '0;
    end else if (gnt0 && starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q   <= PORT_VID;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      pend_q       <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= ram_address;
      pend_q       <= pend_d;
    end
  end

  // Return path is gated by rst_n so a grant just before reset never surfaces.
  assign rvalid0 = rst_n & pend_q.rd  & (pend_q.port == PORT_CPU);
  assign rvalid1 = rst_n & pend_q.rd  & (pend_q.port == PORT_VID);
  assign err0    = rst_n & pend_q.err & (pend_q.port == PORT_CPU);
  assign err1    = rst_n & pend_q.err & (pend_q.port == PORT_VID);
  assign rdata0  = (rvalid0 && !pend_q.err) ? ram_out : '0;
  assign rdata1  = (rvalid1 && !pend_q.err) ? ram_out : '0;

endmodule

// File: tb/tb_ram3840_arbiter.sv
// tb/tb_ram3840_arbiter.sv - self-checking bench for ram3840_arbiter with a RAM3840 model
module tb_ram3840_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_next = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [11:0] addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_load;
  logic [15:0] rdata0, rdata1, ram_in;
  logic [15:0] ram_out = 16'h0;
  logic [11:0] ram_address;

  int tests = 0;
  int fails = 0;

  ram3840_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
    .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // RAM3840 environment: synchronous write, registered read; junk beyond DEPTH.
  logic [15:0] ram_mem [0:3839];
  always @(posedge clk) begin
    if (ram_load && ram_address < 12'd3840) ram_mem[ram_address] <= ram_in;
    ram_out <= (ram_address < 12'd3840) ? ram_mem[ram_address] : 16'hDEAD;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp_v);
    end
  endtask

  // Reference model: grant rules, parked address, one-deep return record, shadow memory.
  logic [15:0] model_mem [0:3839];
  int          m_last = 1, m_streak = 0, m_pport = 0;
  logic        m_pv = 0, m_pe = 0;
  logic [15:0] m_pdata = 0;
  logic [11:0] m_laddr = 0;

  always @(negedge clk) begin
    int w;
    logic [11:0] a;
    logic we, inr, e_ld;
    logic [15:0] d;
    w = -1; a = '0; we = 0; inr = 0; e_ld = 0; d = '0;
    if (!rst_n) begin
      check("rst_gnt0", gnt0, 0);       check("rst_gnt1", gnt1, 0);
      check("rst_load", ram_load, 0);
      check("rst_rvalid0", rvalid0, 0); check("rst_rvalid1", rvalid1, 0);
      check("rst_err0", err0, 0);       check("rst_err1", err1, 0);
      check("rst_rdata0", rdata0, 0);   check("rst_rdata1", rdata1, 0);
      m_last = 1; m_streak = 0; m_pv = 0; m_pe = 0; m_pdata = 0; m_laddr = 0;
    end else begin
      if (req0 && req1) begin
`ifdef RAM3840_ARB_RR_EN
        w = (m_last == 0) ? 1 : 0;
`else
        w = (m_streak >= 4) ? 1 : 0;
`endif
      end else if (req0) w = 0;
      else if (req1) w = 1;
      if (w == 0) begin a = addr0; we = we0; d = wdata0; end
      else if (w == 1) begin a = addr1; we = we1; d = wdata1; end
      if (w >= 0) begin
        inr = (a < 12'd3840);
        e_ld = we && inr;
        m_laddr = a;
      end
      check("gnt0", gnt0, w == 0);
      check("gnt1", gnt1, w == 1);
      check("ram_load", ram_load, e_ld);
      check("ram_address", ram_address, m_laddr);
      if (w >= 0) check("ram_in", ram_in, d);
      check("rvalid0", rvalid0, m_pv && m_pport == 0);
      check("rvalid1", rvalid1, m_pv && m_pport == 1);
      check("err0", err0, m_pe && m_pport == 0);
      check("err1", err1, m_pe && m_pport == 1);
      check("rdata0", rdata0, (m_pv && m_pport == 0) ? m_pdata : 16'h0);
      check("rdata1", rdata1, (m_pv && m_pport == 1) ? m_pdata : 16'h0);
      m_pv = 0; m_pe = 0; m_pdata = 0;
      if (w >= 0) begin
        m_pport = w;
        m_pv = !we;
        m_pe = !inr;
        m_pdata = (!we && inr) ? model_mem[a] : 16'h0;
        if (e_ld) model_mem[a] = d;
        m_last = w;
      end
      if (!req1 || w == 1) m_streak = 0;
      else if (w == 0) m_streak++;
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [15:0] d1);
    @(posedge clk);
    #1;
    rst_n = rst_next;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
  endtask

  logic [9:0] pat;
  logic [9:0] exp_pat;

  initial begin
    for (int i = 0; i < 3840; i++) begin
      ram_mem[i]   = 16'(i) ^ 16'hA5A5;
      model_mem[i] = 16'(i) ^ 16'hA5A5;
    end
`ifdef RAM3840_ARB_RR_EN
    exp_pat = 10'b1010101010;
`else
    exp_pat = 10'b1000010000;
`endif

    // Reset, then idle for 10 cycles
    rst_next = 0;
    repeat (3) idle();
    rst_next = 1;
    for (int i = 0; i < 10; i++) begin
      idle();
      check("idle_gnt", {gnt0, gnt1}, 0);
      check("idle_load", ram_load, 0);
      check("idle_ret", {rvalid0, rvalid1, err0, err1}, 0);
      check("idle_addr", ram_address, 0);
    end

    // Write-then-read on port 0
    drive(1, 1, 12'h005, 16'hBEEF, 0, 0, 12'h0, 16'h0);
    check("wr5_gnt0", gnt0, 1);
    check("wr5_load", ram_load, 1);
    drive(1, 0, 12'h005, 16'h0, 0, 0, 12'h0, 16'h0);
    check("rd5_gnt0", gnt0, 1);
    check("rd5_load", ram_load, 0);
    idle();
    check("rd5_rvalid0", rvalid0, 1);
    check("rd5_rdata0", rdata0, 16'hBEEF);

    // Continuous tie from a fresh reset
    rst_next = 0;
    idle(); idle();
    rst_next = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 12'h010, 16'h0, 1, 0, 12'h020, 16'h0);
      pat[i] = gnt1;
    end
    check("tie_pattern", pat, exp_pat);
    idle();

    // Out-of-range read on port 1
    drive(0, 0, 12'h0, 16'h0, 1, 0, 12'hF00, 16'h0);
    check("oor_gnt1", gnt1, 1);
    check("oor_load", ram_load, 0);
    idle();
    check("oor_ret", {rvalid1, err1}, 2'b11);
    check("oor_rdata1", rdata1, 16'h0);

    // Last valid word, then a rejected write at 0xFFF
    drive(0, 0, 12'h0, 16'h0, 1, 1, 12'hEFF, 16'h1234);
    check("eff_wr_load", ram_load, 1);
    drive(1, 0, 12'hEFF, 16'h0, 0, 0, 12'h0, 16'h0);
    check("eff_rd_gnt0", gnt0, 1);
    drive(1, 1, 12'hFFF, 16'hDEAD, 0, 0, 12'h0, 16'h0);
    check("fff_load", ram_load, 0);
    check("eff_rdata0", rdata0, 16'h1234);
    drive(0, 0, 12'h0, 16'h0, 1, 0, 12'hEFF, 16'h0);
    check("fff_err0", err0, 1);
    check("fff_rvalid0", rvalid0, 0);
    idle();
    check("eff_keep", rdata1, 16'h1234);

    // Reset right after a read grant drops the return
    drive(1, 0, 12'h005, 16'h0, 0, 0, 12'h0, 16'h0);
    check("pre_rst_gnt0", gnt0, 1);
    rst_next = 0;
    idle();
    check("rst_drop_rvalid0", rvalid0, 0);
    idle();
    rst_next = 1;
    drive(1, 0, 12'h005, 16'h0, 1, 0, 12'h006, 16'h0);
    check("post_rst_tie", {gnt0, gnt1}, 2'b10);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
